// File: rtl/ysyx_22050019_lsu.sv
// Memory-access stage: turns EX/MEM load/store controls into one outstanding
// request/response on the data port and registers the result for MEM/WB.
module ysyx_22050019_lsu #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic        commite_i,
    input  logic [63:0] result_i,
    input  logic [63:0] wdata_exu_reg_i,
    input  logic [63:0] wdate_csr_reg_i,
    input  logic        ram_we_i,
    input  logic [63:0] ram_wdata_i,
    input  logic [3:0]  mem_w_wdth_i,
    input  logic        ram_re_i,
    input  logic [5:0]  mem_r_wdth_i,
    input  logic        reg_we_i,
    input  logic [4:0]  reg_waddr_i,
    output logic        stall_o,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic        req_wen_o,
    output logic [63:0] req_addr_o,
    output logic [63:0] req_wdata_o,
    output logic [7:0]  req_wstrb_o,
    input  logic        rsp_valid_i,
    input  logic [63:0] rsp_rdata_i,
    input  logic        rsp_err_i,
    output logic        wb_valid_o,
    output logic [63:0] wb_data_o,
    output logic [63:0] wb_csr_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [63:0] pc_o,
    output logic [31:0] inst_o,
    output logic        commite_o,
    output logic        misalign_o,
    output logic        acc_fault_o
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        wb_valid_q, wb_valid_d;
    logic [63:0] wb_data_q, wb_data_d;
    logic [63:0] wb_csr_q, wb_csr_d;
    logic        reg_we_q, reg_we_d;
    logic [4:0]  reg_waddr_q, reg_waddr_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        commite_q, commite_d;
    logic        misalign_q, misalign_d;
    logic        acc_fault_q, acc_fault_d;

    logic        is_store, is_load, mem_op, misaligned, timeout, stall_c, in_req;
    logic [2:0]  off, size_mask;
    logic [3:0]  size_oh;
    logic [1:0]  size_log2;
    logic [7:0]  byte_mask;
    logic [63:0] ld_sh, load_ext;
    logic        unused_rsvd;

    assign unused_rsvd = mem_r_wdth_i[5];

    // Store has priority over a simultaneous load
    assign is_store = ram_we_i;
    assign is_load  = ram_re_i & ~ram_we_i;
    assign mem_op   = ram_we_i | ram_re_i;
    assign off      = result_i[2:0];
    assign size_oh  = is_store ? mem_w_wdth_i : mem_r_wdth_i[3:0];

    always_comb begin
        size_log2 = 2'd3;
        byte_mask = 8'hFF;
        size_mask = 3'd7;
        if (size_oh[0]) begin
            size_log2 = 2'd0; byte_mask = 8'h01; size_mask = 3'd0;
        end else if (size_oh[1]) begin
            size_log2 = 2'd1; byte_mask = 8'h03; size_mask = 3'd1;
        end else if (size_oh[2]) begin
            size_log2 = 2'd2; byte_mask = 8'h0F; size_mask = 3'd3;
        end
    end

    assign misaligned = mem_op & ((off & size_mask) != 3'd0);
    assign timeout    = (state_q == S_WAIT) & (cnt_q == CNT_LAST) & ~rsp_valid_i;

    // Load result: bring the addressed lane down, then sign/zero extend
    assign ld_sh = rsp_rdata_i >> {off, 3'b000};
    always_comb begin
        load_ext = ld_sh;
        case (size_log2)
            2'd0: load_ext = mem_r_wdth_i[4] ? {56'd0, ld_sh[7:0]}  : {{56{ld_sh[7]}},  ld_sh[7:0]};
            2'd1: load_ext = mem_r_wdth_i[4] ? {48'd0, ld_sh[15:0]} : {{48{ld_sh[15]}}, ld_sh[15:0]};
            2'd2: load_ext = mem_r_wdth_i[4] ? {32'd0, ld_sh[31:0]} : {{32{ld_sh[31]}}, ld_sh[31:0]};
            default: load_ext = ld_sh;
        endcase
    end

    // Request fields are driven straight from the (stalled, stable) inputs
    assign in_req      = (state_q == S_REQ);
    assign req_valid_o = in_req;
    assign req_wen_o   = in_req & is_store;
    assign req_addr_o  = in_req ? {result_i[63:3], 3'b000} : 64'd0;
    assign req_wdata_o = (in_req & is_store) ? (ram_wdata_i << {off, 3'b000}) : 64'd0;
    assign req_wstrb_o = (in_req & is_store) ? (byte_mask << off) : 8'd0;
    assign stall_o     = rst_n & stall_c;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_c     = 1'b0;
        wb_valid_d  = 1'b0;
        wb_data_d   = 64'd0;
        wb_csr_d    = 64'd0;
        reg_we_d    = 1'b0;
        reg_waddr_d = 5'd0;
        pc_d        = 64'd0;
        inst_d      = 32'd0;
        commite_d   = 1'b0;
        misalign_d  = 1'b0;
        acc_fault_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_op && !misaligned) begin
                    stall_c = 1'b1;
                    state_d = S_REQ;
                end else begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = wdata_exu_reg_i;
                    reg_we_d   = reg_we_i & ~misaligned;
                    misalign_d = misaligned;
                end
            end
            S_REQ: begin
                stall_c = 1'b1;
                if (req_ready_i) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                cnt_d   = cnt_q + CNT_W'(1);
                stall_c = ~rsp_valid_i & ~timeout;
                if (rsp_valid_i) begin
                    state_d     = S_IDLE;
                    wb_valid_d  = 1'b1;
                    acc_fault_d = rsp_err_i;
                    reg_we_d    = reg_we_i & ~rsp_err_i;
                    wb_data_d   = is_load ? load_ext : wdata_exu_reg_i;
                end else if (timeout) begin
                    state_d     = S_IDLE;
                    wb_valid_d  = 1'b1;
                    acc_fault_d = 1'b1;
                    wb_data_d   = wdata_exu_reg_i;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (wb_valid_d) begin
            wb_csr_d    = wdate_csr_reg_i;
            reg_waddr_d = reg_waddr_i;
            pc_d        = pc_i;
            inst_d      = inst_i;
            commite_d   = commite_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= 64'd0;
            wb_csr_q    <= 64'd0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= 5'd0;
            pc_q        <= 64'd0;
            inst_q      <= 32'd0;
            commite_q   <= 1'b0;
            misalign_q  <= 1'b0;
            acc_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_csr_q    <= wb_csr_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            commite_q   <= commite_d;
            misalign_q  <= misalign_d;
            acc_fault_q <= acc_fault_d;
        end
    end

    assign wb_valid_o  = wb_valid_q;
    assign wb_data_o   = wb_data_q;
    assign wb_csr_o    = wb_csr_q;
    assign reg_we_o    = reg_we_q;
    assign reg_waddr_o = reg_waddr_q;
    assign pc_o        = pc_q;
    assign inst_o      = inst_q;
    assign commite_o   = commite_q;
    assign misalign_o  = misalign_q;
    assign acc_fault_o = acc_fault_q;

endmodule

// File: tb/tb_ysyx_22050019_lsu.sv
// Directed-vector bench for the LSU: loads, stores, misalign, bus error,
// timeout, reset mid-transaction and back-to-back ALU traffic.
module tb_ysyx_22050019_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] pc_i, result_i, wdata_exu_reg_i, wdate_csr_reg_i, ram_wdata_i, rsp_rdata_i;
    logic [31:0] inst_i;
    logic        commite_i, ram_we_i, ram_re_i, reg_we_i, req_ready_i, rsp_valid_i, rsp_err_i;
    logic [3:0]  mem_w_wdth_i;
    logic [5:0]  mem_r_wdth_i;
    logic [4:0]  reg_waddr_i;
    logic        stall_o, req_valid_o, req_wen_o, wb_valid_o, reg_we_o, commite_o;
    logic        misalign_o, acc_fault_o;
    logic [63:0] req_addr_o, req_wdata_o, wb_data_o, wb_csr_o, pc_o;
    logic [7:0]  req_wstrb_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] inst_o;

    int n_vec = 0;
    int n_err = 0;

    ysyx_22050019_lsu #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .inst_i(inst_i), .commite_i(commite_i),
        .result_i(result_i), .wdata_exu_reg_i(wdata_exu_reg_i), .wdate_csr_reg_i(wdate_csr_reg_i),
        .ram_we_i(ram_we_i), .ram_wdata_i(ram_wdata_i), .mem_w_wdth_i(mem_w_wdth_i),
        .ram_re_i(ram_re_i), .mem_r_wdth_i(mem_r_wdth_i), .reg_we_i(reg_we_i),
        .reg_waddr_i(reg_waddr_i), .stall_o(stall_o), .req_valid_o(req_valid_o),
        .req_ready_i(req_ready_i), .req_wen_o(req_wen_o), .req_addr_o(req_addr_o),
        .req_wdata_o(req_wdata_o), .req_wstrb_o(req_wstrb_o), .rsp_valid_i(rsp_valid_i),
        .rsp_rdata_i(rsp_rdata_i), .rsp_err_i(rsp_err_i), .wb_valid_o(wb_valid_o),
        .wb_data_o(wb_data_o), .wb_csr_o(wb_csr_o), .reg_we_o(reg_we_o),
        .reg_waddr_o(reg_waddr_o), .pc_o(pc_o), .inst_o(inst_o), .commite_o(commite_o),
        .misalign_o(misalign_o), .acc_fault_o(acc_fault_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        pc_i = 64'd0; inst_i = 32'd0; commite_i = 1'b0; result_i = 64'd0;
        wdata_exu_reg_i = 64'd0; wdate_csr_reg_i = 64'd0; ram_we_i = 1'b0;
        ram_wdata_i = 64'd0; mem_w_wdth_i = 4'd0; ram_re_i = 1'b0; mem_r_wdth_i = 6'd0;
        reg_we_i = 1'b0; reg_waddr_i = 5'd0; req_ready_i = 1'b0;
        rsp_valid_i = 1'b0; rsp_rdata_i = 64'd0; rsp_err_i = 1'b0;
    endtask

    // Drives one memory access from IDLE through REQ (ready after rdy_wait cycles) and WAIT
    task automatic run_mem(input int rdy_wait, input logic [63:0] ea, input logic [63:0] wd,
                           input logic [7:0] st, input logic wen,
                           input logic [63:0] rdata, input logic err);
        req_ready_i = 1'b0;
        #1;
        chk("idle_stall", stall_o, 1);
        chk("idle_noreq", req_valid_o, 0);
        tick();
        for (int i = 0; i <= rdy_wait; i++) begin
            chk("req_valid", req_valid_o, 1);
            chk("req_addr", req_addr_o, ea);
            chk("req_wdata", req_wdata_o, wd);
            chk("req_wstrb", req_wstrb_o, 64'(st));
            chk("req_wen", req_wen_o, 64'(wen));
            chk("req_stall", stall_o, 1);
            chk("req_wbv", wb_valid_o, 0);
            chk("req_commite", commite_o, 0);
            req_ready_i = (i == rdy_wait);
            tick();
        end
        req_ready_i = 1'b0;
        chk("wait_noreq", req_valid_o, 0);
        chk("wait_stall", stall_o, 1);
        rsp_valid_i = 1'b1; rsp_rdata_i = rdata; rsp_err_i = err;
        #1;
        chk("rsp_stall", stall_o, 0);
        tick();
        rsp_valid_i = 1'b0; rsp_rdata_i = 64'd0; rsp_err_i = 1'b0;
    endtask

    initial begin
        clr_in();
        rst_n = 1'b0;
        ram_re_i = 1'b1; mem_r_wdth_i = 6'b001000;
        #12;
        chk("rst_stall", stall_o, 0);
        chk("rst_reqv", req_valid_o, 0);
        chk("rst_wbv", wb_valid_o, 0);
        chk("rst_data", wb_data_o, 0);
        chk("rst_flags", {misalign_o, acc_fault_o, commite_o, reg_we_o}, 0);
        clr_in();
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Back-to-back ALU ops
        for (int i = 0; i < 4; i++) begin
            wdata_exu_reg_i = 64'h1000 + 64'(i); pc_i = 64'h80 + 64'(4 * i);
            commite_i = 1'b1; reg_we_i = 1'b1; reg_waddr_i = 5'(i + 1);
            #1;
            chk("alu_stall", stall_o, 0);
            tick();
            chk("alu_wbv", wb_valid_o, 1);
            chk("alu_data", wb_data_o, 64'h1000 + 64'(i));
            chk("alu_pc", pc_o, 64'h80 + 64'(4 * i));
            chk("alu_rd", reg_waddr_o, 64'(i + 1));
            chk("alu_commite", commite_o, 1);
        end

        // lh at 0x8000_0006
        clr_in();
        pc_i = 64'h200; inst_i = 32'h0065_1083; commite_i = 1'b1; result_i = 64'h8000_0006;
        ram_re_i = 1'b1; mem_r_wdth_i = 6'b000010; reg_we_i = 1'b1; reg_waddr_i = 5'd7;
        wdata_exu_reg_i = 64'hDEAD; wdate_csr_reg_i = 64'hC5;
        run_mem(0, 64'h8000_0000, 64'd0, 8'h00, 1'b0, 64'h8123_4567_89AB_CDEF, 1'b0);
        chk("lh_wbv", wb_valid_o, 1);
        chk("lh_data", wb_data_o, 64'hFFFF_FFFF_FFFF_8123);
        chk("lh_we", reg_we_o, 1);
        chk("lh_rd", reg_waddr_o, 7);
        chk("lh_pc", pc_o, 64'h200);
        chk("lh_inst", inst_o, 64'h0065_1083);
        chk("lh_csr", wb_csr_o, 64'hC5);
        chk("lh_commite", commite_o, 1);
        chk("lh_faults", {misalign_o, acc_fault_o}, 0);

        // lhu, same access
        mem_r_wdth_i = 6'b010010;
        run_mem(0, 64'h8000_0000, 64'd0, 8'h00, 1'b0, 64'h8123_4567_89AB_CDEF, 1'b0);
        chk("lhu_data", wb_data_o, 64'h0000_0000_0000_8123);

        // sb at 0x1003
        clr_in();
        ram_we_i = 1'b1; mem_w_wdth_i = 4'b0001; result_i = 64'h1003; ram_wdata_i = 64'hAB;
        wdata_exu_reg_i = 64'h1234; commite_i = 1'b1;
        run_mem(0, 64'h1000, 64'hAB00_0000, 8'h08, 1'b1, 64'd0, 1'b0);
        chk("sb_wbv", wb_valid_o, 1);
        chk("sb_we", reg_we_o, 0);
        chk("sb_data", wb_data_o, 64'h1234);

        // sw at 0x1004 with one cycle of backpressure; load bit also set, store wins
        clr_in();
        ram_we_i = 1'b1; ram_re_i = 1'b1; mem_r_wdth_i = 6'b001000; mem_w_wdth_i = 4'b0100;
        result_i = 64'h1004; ram_wdata_i = 64'h1122_3344;
        run_mem(1, 64'h1000, 64'h1122_3344_0000_0000, 8'hF0, 1'b1, 64'hFFFF, 1'b0);
        chk("sw_wbv", wb_valid_o, 1);
        chk("sw_data", wb_data_o, 0);

        // Misaligned sw at 0x1002
        clr_in();
        ram_we_i = 1'b1; mem_w_wdth_i = 4'b0100; result_i = 64'h1002; reg_we_i = 1'b1;
        ram_wdata_i = 64'h1122_3344; req_ready_i = 1'b1;
        #1;
        chk("mis_stall", stall_o, 0);
        chk("mis_noreq", req_valid_o, 0);
        tick();
        chk("mis_flag", misalign_o, 1);
        chk("mis_wbv", wb_valid_o, 1);
        chk("mis_we", reg_we_o, 0);
        chk("mis_acc", acc_fault_o, 0);
        clr_in();
        tick();
        chk("mis_pulse", misalign_o, 0);

        // ld with ready held low 5 cycles, then bus error
        clr_in();
        ram_re_i = 1'b1; mem_r_wdth_i = 6'b001000; result_i = 64'h2000; reg_we_i = 1'b1;
        run_mem(5, 64'h2000, 64'd0, 8'h00, 1'b0, 64'h1, 1'b1);
        chk("err_wbv", wb_valid_o, 1);
        chk("err_acc", acc_fault_o, 1);
        chk("err_we", reg_we_o, 0);
        clr_in();
        tick();
        chk("err_pulse", acc_fault_o, 0);

        // Timeout after 4 WAIT cycles, late response ignored
        clr_in();
        ram_re_i = 1'b1; mem_r_wdth_i = 6'b000100; result_i = 64'h3004; reg_we_i = 1'b1;
        wdata_exu_reg_i = 64'h99; req_ready_i = 1'b1;
        tick();
        chk("to_req", req_valid_o, 1);
        tick();
        req_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_stall", stall_o, (i < 3) ? 64'd1 : 64'd0);
            chk("to_nowb", wb_valid_o, 0);
            tick();
        end
        chk("to_wbv", wb_valid_o, 1);
        chk("to_acc", acc_fault_o, 1);
        chk("to_we", reg_we_o, 0);
        clr_in();
        wdata_exu_reg_i = 64'h5A; reg_we_i = 1'b1;
        rsp_valid_i = 1'b1; rsp_rdata_i = 64'hBAD; rsp_err_i = 1'b1;
        #1;
        chk("late_stall", stall_o, 0);
        tick();
        chk("late_wbv", wb_valid_o, 1);
        chk("late_acc", acc_fault_o, 0);
        chk("late_data", wb_data_o, 64'h5A);
        chk("late_we", reg_we_o, 1);

        // Reset asserted while in WAIT
        clr_in();
        ram_re_i = 1'b1; mem_r_wdth_i = 6'b001000; result_i = 64'h4000; req_ready_i = 1'b1;
        tick();
        tick();
        req_ready_i = 1'b0;
        chk("rw_stall", stall_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_stall0", stall_o, 0);
        chk("rw_reqv0", req_valid_o, 0);
        chk("rw_wbv0", wb_valid_o, 0);
        clr_in();
        @(negedge clk) rst_n = 1'b1;
        wdata_exu_reg_i = 64'h77; commite_i = 1'b1;
        #1;
        chk("rw_idle_stall", stall_o, 0);
        tick();
        chk("rw_wbv", wb_valid_o, 1);
        chk("rw_data", wb_data_o, 64'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
